rv_plic_claim_ctrl: RTL and testbench
=====================================

# rv_plic_claim_ctrl

Per-target claim/complete sequencer for the RISC-V PLIC. It sits between one `rv_plic_target` instance and the register file and gateways. It turns claim-register reads and complete-register writes into one-hot claim/complete pulses to the per-source gateways. It tracks which sources are in service and masks the target's stale interrupt output so a source is never handed out twice.

## Interface
- `N_SOURCE`, 37: number of interrupt sources; source ID 0 is reserved for "no interrupt".
- `MAX_NEST`, 4: maximum simultaneously claimed sources. Used only when `RV_PLIC_NEST_LIMIT_EN` is defined.
- `SrcWidth`, `$clog2(N_SOURCE+1)`: derived localparam, not overridable.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `irq_i`  in  1  registered interrupt request from the target.
- `irq_id_i`  in  SrcWidth  registered winning ID from the target.
- `claim_re_i`  in  1  claim register read strobe, one cycle per read.
- `claim_rvalid_o`  out  1  claim read data valid.
- `claim_rdata_o`  out  SrcWidth  claimed ID; 0 means nothing claimed.
- `complete_we_i`  in  1  complete register write strobe.
- `complete_wdata_i`  in  SrcWidth  ID being completed.
- `complete_err_o`  out  1  pulse: complete write ignored.
- `claim_o`  out  N_SOURCE  one-hot claim pulse to gateways; bit i = ID i.
- `complete_o`  out  N_SOURCE  one-hot complete pulse to gateways.
- `in_service_o`  out  N_SOURCE  in-service vector.
- `nest_cnt_o`  out  SrcWidth  number of set `in_service_o` bits.
- `irq_o`  out  1  masked interrupt to hart.

## Operation
- State: an `in_service` register (N_SOURCE bits) and a popcount-tracking counter `nest_cnt`, updated incrementally by +1, −1 or 0 per cycle.
- **Claim.** On `claim_re_i`, the ID is granted when all of the following hold:
  - `irq_i` = 1;
  - `irq_id_i` ≠ 0 and `irq_id_i` < N_SOURCE;
  - `in_service[irq_id_i]` = 0 (holdoff);
  - the nest limit is not reached (macro only).
- **On grant:** set `in_service[id]`, pulse `claim_o[id]`, return `id`, increment `nest_cnt`.
- **Otherwise:** return 0, pulse nothing, change no state.
- **Complete.** On `complete_we_i` with `in_service[wdata]` = 1:
  - clear the bit;
  - pulse `complete_o[wdata]`;
  - decrement `nest_cnt`.
- **Ignored completes:** ID 0, ID ≥ N_SOURCE, or ID not in service. These change no state and pulse `complete_err_o`.
- **Simultaneous claim and complete:** both are evaluated against the pre-cycle `in_service` value.
  - Different IDs: both take effect; `nest_cnt` is unchanged.
  - Same ID: complete valid ⇒ claim blocked by holdoff (returns 0); the bit clears.
- `irq_o` = `irq_i & ~in_service[irq_id_i]`, combinational. It is 0 when `irq_id_i` is out of range.
- Back-to-back claim reads are each accepted and each get their own response.

## Timing
- **Reset values:** `claim_rvalid_o` 0, `claim_rdata_o` 0, `claim_o` 0, `complete_o` 0, `complete_err_o` 0, `in_service_o` 0, `nest_cnt_o` 0.
- **Claim:** strobe in cycle N.
  - `claim_rvalid_o` and `claim_rdata_o` are registered and valid in cycle N+1, held for exactly 1 cycle.
  - `claim_o` pulses in N+1.
  - `in_service_o` updates in N+1.
- **Complete:** strobe in cycle N; `complete_o`, `complete_err_o`, `in_service_o` and `nest_cnt_o` update in N+1.
- **Stale ID window:** the target's `irq_id_i` lags a gateway clear by 2 cycles. The holdoff covers this, so a read in N+1 or N+2 never returns the same ID again.
- All pulses are single-cycle.
- Async reset mid-operation: all state clears immediately; pending responses are dropped with no `claim_rvalid_o`.

## Configuration
- `RV_PLIC_NEST_LIMIT_EN` defined:
  - A claim is refused (returns 0, no pulse) while `nest_cnt` ≥ MAX_NEST.
  - `irq_o` is forced 0 while `nest_cnt` ≥ MAX_NEST.
- `RV_PLIC_NEST_LIMIT_EN` undefined:
  - No limit; up to N_SOURCE−1 sources may be in service.
  - MAX_NEST is unused.

## Test plan
- **Basic claim/complete.** `irq_i`=1, `irq_id_i`=5, claim read → next cycle `claim_rdata_o`=5, `claim_o[5]` pulse, `nest_cnt_o`=1. Then complete 5 → `complete_o[5]` pulse, `in_service_o`=0.
- **No interrupt pending.** `irq_i`=0, claim read → `claim_rdata_o`=0, `claim_rvalid_o`=1, no `claim_o` bit set.
- **Stale-ID holdoff.** Claims on 3 consecutive cycles with `irq_id_i` held at 7 → responses 7, 0, 0. `irq_o`=0 while 7 is in service.
- **Bad completes.** Complete 9 when not in service, complete 0, complete 40 → `complete_err_o` pulses 3 times; `in_service_o` unchanged.
- **Simultaneous claim and complete.** Claim of 4 concurrent with complete of 2 (2 in service) → `claim_o[4]` and `complete_o[2]` pulse in the same cycle; `nest_cnt_o` unchanged. Same-ID case (complete 6 with claim while `irq_id_i`=6) → claim returns 0, bit 6 clears.
- **Nest limit and reset.** With `RV_PLIC_NEST_LIMIT_EN`, MAX_NEST=2: claims of 1, 2, 3 → responses 1, 2, 0; `irq_o` forced 0. Assert `rst_ni` low mid-claim → all outputs 0 and no response.

Source files
------------

// File: rtl/rv_plic_claim_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_plic_claim_ctrl_if
//
// This interface bundles the signals between rv_plic_claim_ctrl and its
// neighbours:
//   - the target side: irq_i, irq_id_i;
//   - the claim register read port: claim_re_i, claim_rvalid_o, claim_rdata_o;
//   - the complete register write port: complete_we_i, complete_wdata_i,
//     complete_err_o;
//   - the gateway side: claim_o, complete_o;
//   - status outputs: in_service_o, nest_cnt_o;
//   - the hart side: irq_o.
//
// Signal suffixes follow the claim controller's point of view.
//   slave  : the modport that rv_plic_claim_ctrl uses.
//   master : the modport for the surrounding logic or testbench.
// ---------------------------------------------------------------------------
interface rv_plic_claim_ctrl_if #(
    parameter int N_SOURCE = 37
);
    localparam int SrcWidth = $clog2(N_SOURCE + 1);

    logic                irq_i;
    logic [SrcWidth-1:0] irq_id_i;
    logic                claim_re_i;
    logic                claim_rvalid_o;
    logic [SrcWidth-1:0] claim_rdata_o;
    logic                complete_we_i;
    logic [SrcWidth-1:0] complete_wdata_i;
    logic                complete_err_o;
    logic [N_SOURCE-1:0] claim_o;
    logic [N_SOURCE-1:0] complete_o;
    logic [N_SOURCE-1:0] in_service_o;
    logic [SrcWidth-1:0] nest_cnt_o;
    logic                irq_o;

    modport slave (
        input  irq_i, irq_id_i, claim_re_i, complete_we_i, complete_wdata_i,
        output claim_rvalid_o, claim_rdata_o, complete_err_o, claim_o,
               complete_o, in_service_o, nest_cnt_o, irq_o
    );

    modport master (
        output irq_i, irq_id_i, claim_re_i, complete_we_i, complete_wdata_i,
        input  claim_rvalid_o, claim_rdata_o, complete_err_o, claim_o,
               complete_o, in_service_o, nest_cnt_o, irq_o
    );
endinterface

// File: rtl/rv_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// rv_plic_claim_ctrl
//
// This module is the per-target claim/complete sequencer for the RISC-V PLIC.
//
// Claim and complete behaviour:
//   - A claim register read grants the target's winning ID when that source
//     is not already in service.
//   - A complete register write retires an in-service source.
//   - Both kinds of request generate one-hot pulses to the per-source
//     gateways.
//
// The in-service vector masks the target's interrupt output while its
// winning ID is being serviced. This covers the two-cycle window in which
// the target still reports an ID that the gateway has already cleared.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     rv_plic_claim_ctrl_if.slave, which carries:
//     - the target request: irq_i, irq_id_i;
//     - the claim read port: claim_re_i -> claim_rvalid_o, claim_rdata_o;
//     - the complete write port: complete_we_i, complete_wdata_i ->
//       complete_err_o;
//     - the gateway pulses: claim_o, complete_o;
//     - status: in_service_o, nest_cnt_o;
//     - the masked hart interrupt: irq_o.
//
// Optional feature:
//   RV_PLIC_NEST_LIMIT_EN  When this macro is defined, claims are refused and
//                          irq_o is held low while MAX_NEST sources are in
//                          service.
// ---------------------------------------------------------------------------
module rv_plic_claim_ctrl #(
    parameter int N_SOURCE = 37,
    parameter int MAX_NEST = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    rv_plic_claim_ctrl_if.slave bus
);
    localparam int SrcWidth = $clog2(N_SOURCE + 1);
    localparam logic [SrcWidth-1:0] NumSrcId = SrcWidth'(N_SOURCE);

`ifdef RV_PLIC_NEST_LIMIT_EN
    localparam int NestLimit = MAX_NEST;
`else
    // Without the limit the threshold is set at or above N_SOURCE.
    // The counter tops out at N_SOURCE-1, so it never reaches this threshold.
    localparam int NestLimit = (MAX_NEST > N_SOURCE) ? MAX_NEST : N_SOURCE;
`endif

    // This function returns a one-hot decode of a source ID.
    // ID 0 and IDs >= N_SOURCE decode to all zeros.
    // As a result, the range checks fall out of the AND with in_service.
    function automatic logic [N_SOURCE-1:0] id_decode(input logic [SrcWidth-1:0] id);
        logic [N_SOURCE-1:0] onehot;
        onehot = '0;
        for (int i = 1; i < N_SOURCE; i++) begin
            if (id == SrcWidth'(i)) begin
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

    logic [N_SOURCE-1:0] in_service_q, in_service_d;
    logic [SrcWidth-1:0] nest_cnt_q, nest_cnt_d;
    logic                claim_rvalid_q, claim_rvalid_d;
    logic [SrcWidth-1:0] claim_rdata_q, claim_rdata_d;
    logic [N_SOURCE-1:0] claim_q, claim_d;
    logic [N_SOURCE-1:0] complete_q, complete_d;
    logic                complete_err_q, complete_err_d;

    logic [N_SOURCE-1:0] irq_onehot;
    logic [N_SOURCE-1:0] cpl_onehot;
    logic                irq_held;
    logic                nest_full;
    logic                claim_grant;
    logic                cpl_valid;

    assign irq_onehot = id_decode(bus.irq_id_i);
    assign cpl_onehot = id_decode(bus.complete_wdata_i);
    assign irq_held   = |(irq_onehot & in_service_q);
    assign nest_full  = (int'(nest_cnt_q) >= NestLimit);

    // The claim and the complete are both judged against the pre-cycle
    // in_service value. For the same ID, the holdoff therefore blocks the
    // claim while the complete clears the bit. This keeps the two updates
    // disjoint.
    assign claim_grant = bus.claim_re_i & bus.irq_i & (|irq_onehot) & ~irq_held & ~nest_full;
    assign cpl_valid   = bus.complete_we_i & (|(cpl_onehot & in_service_q));

    always_comb begin
        claim_rvalid_d = bus.claim_re_i;
        claim_rdata_d  = '0;
        claim_d        = '0;
        complete_d     = '0;
        complete_err_d = bus.complete_we_i & ~cpl_valid;
        nest_cnt_d     = nest_cnt_q;

        if (claim_grant) begin
            claim_rdata_d = bus.irq_id_i;
            claim_d       = irq_onehot;
        end
        if (cpl_valid) begin
            complete_d = cpl_onehot;
        end

        in_service_d = (in_service_q | claim_d) & ~complete_d;

        // The counter follows the popcount of in_service. A simultaneous
        // grant and retire cancel each other out.
        case ({claim_grant, cpl_valid})
            2'b10:   nest_cnt_d = nest_cnt_q + SrcWidth'(1);
            2'b01:   nest_cnt_d = nest_cnt_q - SrcWidth'(1);
            default: nest_cnt_d = nest_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_service_q   <= '0;
            nest_cnt_q     <= '0;
            claim_rvalid_q <= 1'b0;
            claim_rdata_q  <= '0;
            claim_q        <= '0;
            complete_q     <= '0;
            complete_err_q <= 1'b0;
        end else begin
            in_service_q   <= in_service_d;
            nest_cnt_q     <= nest_cnt_d;
            claim_rvalid_q <= claim_rvalid_d;
            claim_rdata_q  <= claim_rdata_d;
            claim_q        <= claim_d;
            complete_q     <= complete_d;
            complete_err_q <= complete_err_d;
        end
    end

    assign bus.claim_rvalid_o = claim_rvalid_q;
    assign bus.claim_rdata_o  = claim_rdata_q;
    assign bus.claim_o        = claim_q;
    assign bus.complete_o     = complete_q;
    assign bus.complete_err_o = complete_err_q;
    assign bus.in_service_o   = in_service_q;
    assign bus.nest_cnt_o     = nest_cnt_q;

    // ID 0 has no in-service bit, so it is never masked here.
    // IDs at or beyond N_SOURCE are always masked.
    assign bus.irq_o = bus.irq_i & (bus.irq_id_i < NumSrcId) & ~irq_held & ~nest_full;

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_plic_claim_ctrl
//
// This is the testbench for rv_plic_claim_ctrl, built with N_SOURCE = 37 and
// MAX_NEST = 2. It runs in four parts:
//   - A directed vector table covers claim, holdoff, bad completes,
//     simultaneous claim/complete and the ID boundaries.
//   - Hand-written sequences cover the nest limit and an asynchronous reset
//     in the middle of a claim.
//   - A randomized phase follows.
//   - The randomized phase is checked against a set-of-sources reference
//     model.
// ---------------------------------------------------------------------------
module tb_rv_plic_claim_ctrl;
    localparam int N       = 37;
    localparam int MaxNest = 2;
    localparam int SrcW    = $clog2(N + 1);
`ifdef RV_PLIC_NEST_LIMIT_EN
    localparam bit NestEn = 1'b1;
`else
    localparam bit NestEn = 1'b0;
`endif

    typedef struct {
        bit irq;
        int id;
        bit re;
        bit we;
        int wd;
    } in_t;

    typedef struct {
        bit          irq_o;
        bit          rvalid;
        int          rdata;
        logic [63:0] claim;
        logic [63:0] cpl;
        bit          err;
        logic [63:0] insvc;
        int          nest;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    // The reference model is the set of sources currently in service.
    bit   svc[N];

    vec_t tbl[18];

    rv_plic_claim_ctrl_if #(.N_SOURCE(N)) bus ();

    rv_plic_claim_ctrl #(
        .N_SOURCE(N),
        .MAX_NEST(MaxNest)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] bit_of(input int n);
        return 64'(1) << n;
    endfunction

    function automatic vec_t mk(input bit irq, input int id, input bit re, input bit we,
                                input int wd, input bit irq_o, input int rdata,
                                input int claim_id, input int cpl_id, input bit err,
                                input logic [63:0] insvc, input int nest);
        vec_t v;
        v.i.irq    = irq;
        v.i.id     = id;
        v.i.re     = re;
        v.i.we     = we;
        v.i.wd     = wd;
        v.e.irq_o  = irq_o;
        v.e.rvalid = re;
        v.e.rdata  = rdata;
        v.e.claim  = (claim_id < 0) ? 64'(0) : bit_of(claim_id);
        v.e.cpl    = (cpl_id < 0) ? 64'(0) : bit_of(cpl_id);
        v.e.err    = err;
        v.e.insvc  = insvc;
        v.e.nest   = nest;
        return v;
    endfunction

    // This function predicts the next cycle from the set of sources in
    // service, using the grant and retire rules directly.
    function automatic exp_t modelPredict(input in_t i);
        exp_t e;
        int   cnt;
        bit   full, held, grant, cv, nxt;
        cnt = 0;
        for (int k = 0; k < N; k++) cnt += int'(svc[k]);
        full  = NestEn && (cnt >= MaxNest);
        held  = 1'b0;
        if (i.id < N) held = svc[i.id];
        grant = i.re && i.irq && (i.id != 0) && (i.id < N) && !held && !full;
        cv    = i.we && (i.wd != 0) && (i.wd < N);
        if (cv) cv = svc[i.wd];
        e.irq_o  = i.irq && (i.id < N) && !held && !full;
        e.rvalid = i.re;
        e.rdata  = grant ? i.id : 0;
        e.claim  = grant ? bit_of(i.id) : 64'(0);
        e.cpl    = cv ? bit_of(i.wd) : 64'(0);
        e.err    = i.we && !cv;
        e.insvc  = '0;
        e.nest   = 0;
        for (int k = 0; k < N; k++) begin
            nxt = svc[k];
            if (grant && k == i.id) nxt = 1'b1;
            if (cv && k == i.wd) nxt = 1'b0;
            e.insvc[k] = nxt;
            e.nest += int'(nxt);
        end
        return e;
    endfunction

    task automatic modelCommit(input exp_t e);
        for (int k = 0; k < N; k++) svc[k] = e.insvc[k];
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) svc[k] = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // This task drives one cycle of inputs and samples the combinational
    // irq_o. It then steps past the edge so that the registered outputs
    // reflect this cycle.
    task automatic applyStimulus(input in_t i, output logic irq_o_pre);
        bus.irq_i            = i.irq;
        bus.irq_id_i         = SrcW'(i.id);
        bus.claim_re_i       = i.re;
        bus.complete_we_i    = i.we;
        bus.complete_wdata_i = SrcW'(i.wd);
        #1;
        irq_o_pre = bus.irq_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic runVector(input string tag, input in_t i, input exp_t e);
        logic pre;
        exp_t m;
        m = modelPredict(i);
        applyStimulus(i, pre);
        modelCommit(m);
        checkOutput({tag, " irq_o"},        64'(pre),                 64'(e.irq_o));
        checkOutput({tag, " rvalid"},       64'(bus.claim_rvalid_o),  64'(e.rvalid));
        checkOutput({tag, " rdata"},        64'(bus.claim_rdata_o),   64'(e.rdata));
        checkOutput({tag, " claim_o"},      64'(bus.claim_o),         e.claim);
        checkOutput({tag, " complete_o"},   64'(bus.complete_o),      e.cpl);
        checkOutput({tag, " complete_err"}, 64'(bus.complete_err_o),  64'(e.err));
        checkOutput({tag, " in_service"},   64'(bus.in_service_o),    e.insvc);
        checkOutput({tag, " nest_cnt"},     64'(bus.nest_cnt_o),      64'(e.nest));
    endtask

    task automatic runModel(input string tag, input in_t i);
        runVector(tag, i, modelPredict(i));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rvalid"},       64'(bus.claim_rvalid_o), 64'(0));
        checkOutput({tag, " rdata"},        64'(bus.claim_rdata_o),  64'(0));
        checkOutput({tag, " claim_o"},      64'(bus.claim_o),        64'(0));
        checkOutput({tag, " complete_o"},   64'(bus.complete_o),     64'(0));
        checkOutput({tag, " complete_err"}, 64'(bus.complete_err_o), 64'(0));
        checkOutput({tag, " in_service"},   64'(bus.in_service_o),   64'(0));
        checkOutput({tag, " nest_cnt"},     64'(bus.nest_cnt_o),     64'(0));
    endtask

    initial begin
        in_t  r;
        vec_t v;

        //                irq id re we wd   irq_o rd  clm cpl err in_service         nest
        tbl[0]  = mk(1,  5, 1, 0,  0,   1,  5,  5, -1, 0, bit_of(5),              1);
        tbl[1]  = mk(0,  0, 0, 1,  5,   0,  0, -1,  5, 0, 64'(0),                 0);
        tbl[2]  = mk(0,  0, 1, 0,  0,   0,  0, -1, -1, 0, 64'(0),                 0);
        tbl[3]  = mk(1,  7, 1, 0,  0,   1,  7,  7, -1, 0, bit_of(7),              1);
        tbl[4]  = mk(1,  7, 1, 0,  0,   0,  0, -1, -1, 0, bit_of(7),              1);
        tbl[5]  = mk(1,  7, 1, 0,  0,   0,  0, -1, -1, 0, bit_of(7),              1);
        tbl[6]  = mk(0,  0, 0, 1,  9,   0,  0, -1, -1, 1, bit_of(7),              1);
        tbl[7]  = mk(0,  0, 0, 1,  0,   0,  0, -1, -1, 1, bit_of(7),              1);
        tbl[8]  = mk(0,  0, 0, 1, 40,   0,  0, -1, -1, 1, bit_of(7),              1);
        tbl[9]  = mk(0,  0, 0, 1,  7,   0,  0, -1,  7, 0, 64'(0),                 0);
        tbl[10] = mk(1,  2, 1, 0,  0,   1,  2,  2, -1, 0, bit_of(2),              1);
        tbl[11] = mk(1,  4, 1, 1,  2,   1,  4,  4,  2, 0, bit_of(4),              1);
        tbl[12] = mk(1,  6, 1, 0,  0,   1,  6,  6, -1, 0, bit_of(4) | bit_of(6),  2);
        tbl[13] = mk(1,  6, 1, 1,  6,   0,  0, -1,  6, 0, bit_of(4),              1);
        tbl[14] = mk(0,  0, 0, 1,  4,   0,  0, -1,  4, 0, 64'(0),                 0);
        tbl[15] = mk(1, 37, 1, 0,  0,   0,  0, -1, -1, 0, 64'(0),                 0);
        tbl[16] = mk(1, 36, 1, 0,  0,   1, 36, 36, -1, 0, bit_of(36),             1);
        tbl[17] = mk(0,  0, 0, 1, 36,   0,  0, -1, 36, 0, 64'(0),                 0);

        bus.irq_i            = 1'b0;
        bus.irq_id_i         = '0;
        bus.claim_re_i       = 1'b0;
        bus.complete_we_i    = 1'b0;
        bus.complete_wdata_i = '0;
        modelReset();

        repeat (2) @(posedge clk_i);
        #1;
        checkAllZero("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checkAllZero("after_reset");

        for (int k = 0; k < 18; k++) begin
            runVector($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
        end

        // Nest limit: the third claim is refused only when the limit is built in.
        v = mk(1, 1, 1, 0, 0, 1, 1, 1, -1, 0, bit_of(1), 1);
        runVector("nest1", v.i, v.e);
        v = mk(1, 2, 1, 0, 0, 1, 2, 2, -1, 0, bit_of(1) | bit_of(2), 2);
        runVector("nest2", v.i, v.e);
        if (NestEn) v = mk(1, 3, 1, 0, 0, 0, 0, -1, -1, 0, bit_of(1) | bit_of(2), 2);
        else        v = mk(1, 3, 1, 0, 0, 1, 3,  3, -1, 0, bit_of(1) | bit_of(2) | bit_of(3), 3);
        runVector("nest3", v.i, v.e);
        for (int k = 1; k <= 3; k++) begin
            r = '{irq: 1'b0, id: 0, re: 1'b0, we: 1'b1, wd: k};
            runModel($sformatf("nest_cpl%0d", k), r);
        end

        // Async reset while a claim response is on the bus and another claim
        // strobe is pending.
        r = '{irq: 1'b1, id: 11, re: 1'b1, we: 1'b0, wd: 0};
        runModel("rst_claim11", r);
        r = '{irq: 1'b1, id: 12, re: 1'b1, we: 1'b0, wd: 0};
        runModel("rst_claim12", r);
        rst_ni = 1'b0;
        #1;
        checkAllZero("async_rst");
        modelReset();
        @(posedge clk_i);
        #1;
        checkAllZero("rst_held");
        bus.claim_re_i = 1'b0;
        bus.irq_i      = 1'b0;
        rst_ni         = 1'b1;
        @(posedge clk_i);
        #1;
        checkAllZero("rst_release");

        for (int k = 0; k < 400; k++) begin
            r.irq = ($urandom_range(0, 9) < 7);
            r.id  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 63));
            r.re  = 1'($urandom_range(0, 1));
            r.we  = ($urandom_range(0, 9) < 4);
            r.wd  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 63));
            runModel($sformatf("rnd%0d", k), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
